// File: rtl/fused_pkg.sv
// Shared types and defaults for the fused OFM writeback path
// between a CONV stage and the following 1x1 stage.
package fused_pkg;

    typedef enum logic [1:0] {
        ACT_BYPASS = 2'd0,
        ACT_RELU   = 2'd1,
        ACT_RELU6  = 2'd2
    } act_mode_e;

    typedef enum logic [1:0] {
        UNCFG,
        ACCEPT,
        DRAIN,
        STALL
    } wb_state_e;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_BUS_W  = 32;

endpackage

// File: rtl/fused_ofm_writeback_act_lane.sv
// Per-channel signed activation: bypass, ReLU or ReLU6 clamp.
// Mode 3 is not a defined encoding and falls through to bypass.
module act_lane
    import fused_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] x,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] clamp_max,
    output logic [DATA_W-1:0] y
);

    logic neg;
    logic over;

    assign neg  = x[DATA_W-1];
    assign over = $signed(x) > $signed(clamp_max);

    always_comb begin
        y = x;
        unique case (1'b1)
            (mode == ACT_RELU): begin
                if (neg) y = '0;
            end
            (mode == ACT_RELU6): begin
                if (neg) y = '0;
                else if (over) y = clamp_max;
            end
            default: y = x;
        endcase
    end

endmodule

// File: rtl/fused_ofm_writeback.sv
// Activation, pixel capture and word-serial writeback into a
// two-bank ping-pong RAM with a ready/release consumer handshake.
module fused_ofm_writeback
    import fused_pkg::*;
#(
    parameter int NUM_CH  = 16,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int BUS_W   = DEF_BUS_W,
    parameter int BANK_AW = 10,
    parameter int PIX_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [1:0]               cfg_act_mode,
    input  logic [DATA_W-1:0]        cfg_clamp_max,
    input  logic [PIX_W-1:0]         cfg_tile_pix,
    input  logic                     in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     in_ready,
    output logic                     wr_en,
    output logic [BANK_AW:0]         wr_addr,
    output logic [BUS_W-1:0]         wr_data,
    output logic                     rd_bank_ready,
    output logic                     rd_bank,
    input  logic                     rd_release,
    output logic                     tile_done
);

    localparam int B  = BUS_W / DATA_W;
    localparam int W  = NUM_CH / B;
    localparam int KW = (W > 1) ? $clog2(W) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(W - 1);

    wb_state_e               state_q;
    logic [1:0]              mode_q;
    logic [DATA_W-1:0]       clamp_q;
    logic [PIX_W-1:0]        tile_q;
    logic [PIX_W-1:0]        pix_cnt_q;
    logic [KW-1:0]           k_q;
    logic [W-1:0][BUS_W-1:0] pix_q;
    logic [1:0]              bank_full_q;
    logic [1:0]              bank_full_d;
    logic                    wr_bank_q;
    logic                    rd_bank_q;

    logic [NUM_CH*DATA_W-1:0] act_data;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        act_lane #(
            .DATA_W(DATA_W)
        ) u_lane (
            .x        (in_data[c*DATA_W +: DATA_W]),
            .mode     (mode_q),
            .clamp_max(clamp_q),
            .y        (act_data[c*DATA_W +: DATA_W])
        );
    end

    logic [PIX_W-1:0]   last_idx;
    logic               drain;
    logic               last_word;
    logic               last_pix;
    logic               tile_end;
    logic               rel_ok;
    logic               hs;
    logic [BANK_AW-1:0] word_idx;

    // A zero tile size behaves as a one-pixel tile.
    assign last_idx  = (tile_q == '0) ? '0 : tile_q - 1'b1;
    assign drain     = (state_q == DRAIN);
    assign last_word = (k_q == K_LAST);
    assign last_pix  = (pix_cnt_q == last_idx);
    assign tile_end  = drain && last_word && last_pix;
    assign rel_ok    = rd_release && bank_full_q[rd_bank_q];
    assign word_idx  = BANK_AW'(pix_cnt_q) * BANK_AW'(W)
                     + BANK_AW'(k_q);

    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            ACCEPT:  in_ready = !bank_full_q[wr_bank_q];
            DRAIN:   in_ready = last_word && !last_pix
                              && !bank_full_q[wr_bank_q];
            default: in_ready = 1'b0;
        endcase
        // A pixel offered alongside start would be lost.
        if (start) in_ready = 1'b0;
    end

    assign hs = in_valid && in_ready;

    always_comb begin
        bank_full_d = bank_full_q;
        if (rel_ok)   bank_full_d[rd_bank_q] = 1'b0;
        if (tile_end) bank_full_d[wr_bank_q] = 1'b1;
    end

    assign wr_en         = drain;
    assign wr_addr       = drain ? {wr_bank_q, word_idx} : '0;
    assign wr_data       = drain ? pix_q[k_q] : '0;
    assign tile_done     = tile_end;
    assign rd_bank_ready = bank_full_q[rd_bank_q];
    assign rd_bank       = rd_bank_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= UNCFG;
            mode_q      <= '0;
            clamp_q     <= '0;
            tile_q      <= '0;
            pix_cnt_q   <= '0;
            k_q         <= '0;
            pix_q       <= '0;
            bank_full_q <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
        end else if (start) begin
            state_q     <= ACCEPT;
            mode_q      <= cfg_act_mode;
            clamp_q     <= cfg_clamp_max;
            tile_q      <= cfg_tile_pix;
            pix_cnt_q   <= '0;
            k_q         <= '0;
            bank_full_q <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
        end else begin
            bank_full_q <= bank_full_d;
            if (rel_ok) rd_bank_q <= !rd_bank_q;
            if (hs) begin
                pix_q <= act_data;
                k_q   <= '0;
            end
            unique case (state_q)
                ACCEPT: begin
                    if (hs) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (!last_word) begin
                        k_q <= k_q + 1'b1;
                    end else begin
                        if (tile_end) begin
                            pix_cnt_q <= '0;
                            wr_bank_q <= !wr_bank_q;
                        end else begin
                            pix_cnt_q <= pix_cnt_q + 1'b1;
                        end
                        if (hs)
                            state_q <= DRAIN;
                        else if (tile_end && bank_full_d[~wr_bank_q])
                            state_q <= STALL;
                        else
                            state_q <= ACCEPT;
                    end
                end
                STALL: begin
                    if (!bank_full_q[wr_bank_q]) state_q <= ACCEPT;
                end
                default: state_q <= state_q;
            endcase
        end
    end

endmodule

// File: tb/tb_fused_ofm_writeback.sv
// Scoreboard bench for fused_ofm_writeback: driver pushes expected
// RAM writes, a negedge monitor pops and compares them.
module tb_fused_ofm_writeback;

    localparam int NUM_CH  = 16;
    localparam int DATA_W  = 8;
    localparam int BUS_W   = 32;
    localparam int BANK_AW = 10;
    localparam int PIX_W   = 16;
    localparam int B       = BUS_W / DATA_W;
    localparam int W       = NUM_CH / B;
    localparam int PW      = NUM_CH * DATA_W;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [1:0]        cfg_act_mode = '0;
    logic [DATA_W-1:0] cfg_clamp_max = '0;
    logic [PIX_W-1:0]  cfg_tile_pix = '0;
    logic              in_valid = 1'b0;
    logic [PW-1:0]     in_data = '0;
    logic              in_ready;
    logic              wr_en;
    logic [BANK_AW:0]  wr_addr;
    logic [BUS_W-1:0]  wr_data;
    logic              rd_bank_ready;
    logic              rd_bank;
    logic              rd_release = 1'b0;
    logic              tile_done;

    fused_ofm_writeback #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .BUS_W  (BUS_W),
        .BANK_AW(BANK_AW),
        .PIX_W  (PIX_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .cfg_act_mode (cfg_act_mode),
        .cfg_clamp_max(cfg_clamp_max),
        .cfg_tile_pix (cfg_tile_pix),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_bank_ready(rd_bank_ready),
        .rd_bank      (rd_bank),
        .rd_release   (rd_release),
        .tile_done    (tile_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [BANK_AW:0] addr;
        logic [BUS_W-1:0] data;
        logic             last;
    } exp_t;

    exp_t exp_q[$];
    int   hs_cyc[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // Producer-side model (driver only).
    logic [1:0]        m_mode = '0;
    logic [DATA_W-1:0] m_clamp = '0;
    int                m_tile = 1;
    int                m_pix = 0;
    logic              m_wb = 1'b0;
    // Consumer-side model (monitor only).
    logic [1:0]        m_full = '0;
    logic              m_rd = 1'b0;

    logic rel_force = 1'b0;
    logic rel_rand = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        rd_release = rel_force
                   | (rel_rand && ($urandom_range(0, 3) == 0));
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string nm);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout/extra required=event t=%0t",
                 nm, $time);
    endtask

    function automatic logic [DATA_W-1:0] act_ref(
        input logic [DATA_W-1:0] v);
        int x;
        int cl;
        x  = int'($signed(v));
        cl = int'($signed(m_clamp));
        if (m_mode == 2'd1 && x < 0) x = 0;
        if (m_mode == 2'd2) begin
            if (x < 0) x = 0;
            else if (x > cl) x = cl;
        end
        return DATA_W'(x);
    endfunction

    task automatic push_pixel(input logic [PW-1:0] d);
        exp_t e;
        logic [DATA_W-1:0] ch;
        for (int k = 0; k < W; k++) begin
            e.data = '0;
            for (int j = 0; j < B; j++) begin
                ch = act_ref(d[(k*B+j)*DATA_W +: DATA_W]);
                e.data[j*DATA_W +: DATA_W] = ch;
            end
            e.addr = {m_wb, BANK_AW'(m_pix * W + k)};
            e.last = (m_pix == m_tile - 1) && (k == W - 1);
            exp_q.push_back(e);
        end
        if (m_pix == m_tile - 1) begin
            m_pix = 0;
            m_wb  = ~m_wb;
        end else begin
            m_pix++;
        end
    endtask

    exp_t mon_e;
    logic mon_set;
    logic mon_bank;

    always @(negedge clk) begin
        if (!reset_n) begin
            m_full = '0;
            m_rd   = 1'b0;
            exp_q.delete();
        end else begin
            mon_set = 1'b0;
            mon_bank = 1'b0;
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    note_fail("unexpected_wr");
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_addr", 64'(wr_addr), 64'(mon_e.addr));
                    chk("wr_data", 64'(wr_data), 64'(mon_e.data));
                    chk("tile_done", 64'(tile_done), 64'(mon_e.last));
                    mon_set  = mon_e.last;
                    mon_bank = mon_e.addr[BANK_AW];
                end
            end else begin
                chk("tile_done_idle", 64'(tile_done), 64'd0);
            end
            chk("rd_bank_ready", 64'(rd_bank_ready), 64'(m_full[m_rd]));
            chk("rd_bank", 64'(rd_bank), 64'(m_rd));
            if (rd_release && m_full[m_rd]) begin
                m_full[m_rd] = 1'b0;
                m_rd = ~m_rd;
            end
            if (mon_set) m_full[mon_bank] = 1'b1;
            if (start) begin
                m_full = '0;
                m_rd   = 1'b0;
                exp_q.delete();
            end
        end
    end

    // Tasks below start and end at posedge+1.
    task automatic do_start(input logic [1:0] md,
                            input logic [DATA_W-1:0] cl,
                            input int tile);
        cfg_act_mode  = md;
        cfg_clamp_max = cl;
        cfg_tile_pix  = PIX_W'(tile);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cfg_act_mode  = 2'($urandom);
        cfg_clamp_max = DATA_W'($urandom);
        cfg_tile_pix  = PIX_W'($urandom);
        m_mode  = md;
        m_clamp = cl;
        m_tile  = (tile == 0) ? 1 : tile;
        m_pix   = 0;
        m_wb    = 1'b0;
    endtask

    task automatic send_pixel(input logic [PW-1:0] d);
        bit done;
        done = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        for (int t = 0; t < 400 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                push_pixel(d);
                hs_cyc.push_back(cyc);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) note_fail("handshake_timeout");
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        in_valid = 1'b0;
        while ((exp_q.size() != 0 || wr_en) && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 300) note_fail("drain_timeout");
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [PW-1:0] rand_pix();
        logic [PW-1:0] d;
        logic [DATA_W-1:0] v;
        for (int c = 0; c < NUM_CH; c++) begin
            case ($urandom_range(0, 5))
                0:       v = 8'h80;
                1:       v = 8'h7f;
                2:       v = 8'h00;
                3:       v = 8'h06;
                default: v = DATA_W'($urandom);
            endcase
            d[c*DATA_W +: DATA_W] = v;
        end
        return d;
    endfunction

    function automatic logic [PW-1:0] seq_pix(input int base);
        logic [PW-1:0] d;
        for (int c = 0; c < NUM_CH; c++)
            d[c*DATA_W +: DATA_W] = DATA_W'(base + c);
        return d;
    endfunction

    logic [PW-1:0] t2_pix;
    int            ones;
    int            np;

    initial begin
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_rd_ready", 64'(rd_bank_ready), 64'd0);
        chk("rst_rd_bank", 64'(rd_bank), 64'd0);
        chk("rst_tile_done", 64'(tile_done), 64'd0);
        step(2);
        reset_n = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        chk("uncfg_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        step(1);

        // Bypass, tile 2, channel c = c+1.
        do_start(2'd0, 8'd6, 2);
        send_pixel(seq_pix(1));
        chk("t1_word0", 64'(wr_data), 64'h04030201);
        chk("t1_addr0", 64'(wr_addr), 64'd0);
        send_pixel(seq_pix(17));
        wait_drain();
        chk("t1_rd_ready", 64'(rd_bank_ready), 64'd1);
        chk("t1_rd_bank", 64'(rd_bank), 64'd0);

        // ReLU6 clamp 6, then ReLU on the same pixel.
        t2_pix = seq_pix(-8);
        t2_pix[47:0] = 48'h807f_0706_00fb;
        do_start(2'd2, 8'd6, 1);
        send_pixel(t2_pix);
        chk("t2_relu6_w0", 64'(wr_data), 64'h06060000);
        wait_drain();
        do_start(2'd1, 8'd6, 1);
        send_pixel(t2_pix);
        chk("t2_relu_w0", 64'(wr_data), 64'h07060000);
        wait_drain();
        do_start(2'd3, 8'd6, 1);
        send_pixel(t2_pix);
        chk("t2_mode3_w0", 64'(wr_data), 64'h070600fb);
        wait_drain();

        // Back-to-back pixels, tile 4.
        do_start(2'd0, 8'd0, 4);
        hs_cyc.delete();
        fork
            begin
                for (int i = 0; i < 4; i++) send_pixel(seq_pix(i * 16));
                in_valid = 1'b0;
            end
            begin
                int t;
                t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!wr_en && t < 50);
                ones = wr_en ? 1 : 0;
                repeat (W * 4 - 1) begin
                    @(negedge clk);
                    if (wr_en) ones++;
                end
                @(negedge clk);
                chk("t3_wr_after", 64'(wr_en), 64'd0);
                chk("t3_wr_run", 64'(ones), 64'(W * 4));
            end
        join
        for (int i = 1; i < 4; i++)
            chk("t3_hs_gap", 64'(hs_cyc[i] - hs_cyc[0]), 64'(W * i));
        wait_drain();

        // Ping-pong stall with tile 1 and no release.
        do_start(2'd1, 8'd0, 1);
        send_pixel(rand_pix());
        send_pixel(rand_pix());
        wait_drain();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_stall_ready", 64'(in_ready), 64'd0);
        end
        step(1);
        rel_force = 1'b1;
        step(1);
        rel_force = 1'b0;
        send_pixel(rand_pix());
        wait_drain();

        // Release of bank 0 in the same cycle bank 1 completes.
        do_start(2'd0, 8'd0, 1);
        send_pixel(rand_pix());
        send_pixel(rand_pix());
        step(W - 1);
        rel_force = 1'b1;
        step(1);
        rel_force = 1'b0;
        send_pixel(rand_pix());
        wait_drain();
        chk("t5_rd_ready", 64'(rd_bank_ready), 64'd1);
        chk("t5_rd_bank", 64'(rd_bank), 64'd1);

        // Start mid-drain aborts the tile without tile_done.
        do_start(2'd0, 8'd0, 1);
        send_pixel(rand_pix());
        in_valid = 1'b0;
        step(1);
        do_start(2'd0, 8'd0, 1);
        chk("t6_no_wr", 64'(wr_en), 64'd0);
        send_pixel(rand_pix());
        chk("t6_addr0", 64'(wr_addr), 64'd0);
        in_valid = 1'b0;

        // Reset mid-drain clears outputs asynchronously.
        #1;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_wr_en", 64'(wr_en), 64'd0);
        chk("t6_rst_addr", 64'(wr_addr), 64'd0);
        chk("t6_rst_data", 64'(wr_data), 64'd0);
        chk("t6_rst_ready", 64'(in_ready), 64'd0);
        chk("t6_rst_rd_ready", 64'(rd_bank_ready), 64'd0);
        m_pix = 0;
        m_wb  = 1'b0;
        step(1);
        reset_n = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_post_rst_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        step(1);
        do_start(2'd2, 8'd5, 2);
        send_pixel(rand_pix());
        chk("t6_rst_addr0", 64'(wr_addr), 64'd0);
        wait_drain();

        // Randomized traffic with random consumer releases.
        rel_rand = 1'b1;
        for (int it = 0; it < 24; it++) begin
            wait_drain();
            do_start(2'($urandom_range(0, 3)),
                     DATA_W'($urandom_range(0, 127)),
                     $urandom_range(0, 4));
            np = $urandom_range(4, 14);
            for (int p = 0; p < np; p++) begin
                in_valid = 1'b0;
                in_data  = rand_pix();
                step($urandom_range(0, 3));
                send_pixel(rand_pix());
            end
        end
        wait_drain();
        rel_rand = 1'b0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=done");
        $fatal(1, "global timeout");
    end

endmodule
